// File: rtl/pc_seq_pkg.sv
// Shared constants and next-PC source encoding for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_SEQ_ADDR_W      = 5;
  localparam int unsigned PC_SEQ_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    JUMP,
    CALL,
    RET
  } pc_src_e;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for pc_sequencer: push/pop with full/empty/level status.
// Entry contents are not reset; they are only read while level_o > 0.
module pc_return_stack
  import pc_seq_pkg::*;
#(
  parameter  int unsigned ADDR_W = PC_SEQ_ADDR_W,
  parameter  int unsigned DEPTH  = PC_SEQ_STACK_DEPTH,
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] top_o,
  output logic [LVL_W-1:0]  level_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign wr_ptr  = PTR_W'(level_q);
  assign rd_ptr  = PTR_W'(level_q - LVL_W'(1));
  assign top_o   = mem_q[rd_ptr];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    if (push_i && !full_o) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_i && !empty_o) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment/jump/call/return with halt at all-ones PC.
// Define PC_SEQ_RETURN_STACK_EN to enable the call/return stack; otherwise call acts as jump.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter  int unsigned ADDR_W      = PC_SEQ_ADDR_W,
  parameter  int unsigned STACK_DEPTH = PC_SEQ_STACK_DEPTH,
  localparam int unsigned LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_done,
  input  logic              stall,
  input  logic              jump_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [ADDR_W-1:0] jump_address,
  output logic [ADDR_W-1:0] program_counter,
  output logic              halted,
  output logic [LVL_W-1:0]  stack_level,
  output logic              stack_err
);

  pc_src_e           src;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              active;

  assign pc_inc          = pc_q + ADDR_W'(1);
  assign halted          = &pc_q;
  assign active          = load_done && !stall && !halted;
  assign program_counter = pc_q;

`ifdef PC_SEQ_RETURN_STACK_EN
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;
  logic              err_q, err_d;

  // Overflowing call / underflowing return degrade to a plain increment.
  always_comb begin
    src   = HOLD;
    err_d = err_q;
    if (active) begin
      if (ret_en) begin
        if (stk_empty) begin
          src   = INC;
          err_d = 1'b1;
        end else begin
          src = RET;
        end
      end else if (call_en) begin
        if (stk_full) begin
          src   = INC;
          err_d = 1'b1;
        end else begin
          src = CALL;
        end
      end else if (jump_en) begin
        src = JUMP;
      end else begin
        src = INC;
      end
    end
  end

  pc_return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (src == CALL),
    .pop_i   (src == RET),
    .data_i  (pc_inc),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .top_o   (stk_top),
    .level_o (stack_level)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign stack_err = err_q;
`else
  logic unused_ret;
  assign unused_ret = ret_en;

  always_comb begin
    src = HOLD;
    if (active) begin
      src = (call_en || jump_en) ? JUMP : INC;
    end
  end

  assign stack_level = '0;
  assign stack_err   = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    case (src)
      INC:       pc_d = pc_inc;
      JUMP, CALL: pc_d = jump_address;
`ifdef PC_SEQ_RETURN_STACK_EN
      RET:       pc_d = stk_top;
`endif
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer against a queue-based reference model.
// Builds with or without PC_SEQ_RETURN_STACK_EN; the model follows the same macro.
module tb_pc_sequencer;

  localparam int unsigned AW     = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LW     = $clog2(DEPTH + 1);
  localparam int unsigned PC_MAX = (1 << AW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          load_done, stall, jump_en, call_en, ret_en;
  logic [AW-1:0] jump_address;
  logic [AW-1:0] program_counter;
  logic          halted;
  logic [LW-1:0] stack_level;
  logic          stack_err;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  int unsigned m_pc;
  int unsigned m_stack[$];
  bit          m_err;

  pc_sequencer #(
    .ADDR_W      (AW),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .load_done       (load_done),
    .stall           (stall),
    .jump_en         (jump_en),
    .call_en         (call_en),
    .ret_en          (ret_en),
    .jump_address    (jump_address),
    .program_counter (program_counter),
    .halted          (halted),
    .stack_level     (stack_level),
    .stack_err       (stack_err)
  );

  always #5 CLK = ~CLK;

  function automatic int unsigned m_level();
`ifdef PC_SEQ_RETURN_STACK_EN
    return unsigned'(m_stack.size());
`else
    return 0;
`endif
  endfunction

  function automatic logic [AW+LW+1:0] exp_state();
    return {AW'(m_pc), LW'(m_level()), m_err, (m_pc == PC_MAX)};
  endfunction

  task automatic model_reset();
    m_pc  = 0;
    m_err = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_step(input bit ld, input bit st, input bit j, input bit c,
                            input bit r, input int unsigned addr);
    int unsigned nxt;
    nxt = (m_pc + 1) % (PC_MAX + 1);
    if (!ld || st || m_pc == PC_MAX) return;
`ifdef PC_SEQ_RETURN_STACK_EN
    if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_err = 1'b1; m_pc = nxt; end
    end else if (c) begin
      if (m_stack.size() < int'(DEPTH)) begin m_stack.push_back(nxt); m_pc = addr; end
      else begin m_err = 1'b1; m_pc = nxt; end
    end else if (j) m_pc = addr;
    else m_pc = nxt;
`else
    if (c || j) m_pc = addr;
    else m_pc = nxt;
`endif
  endtask

  task automatic tick(input bit ld, input bit st, input bit j, input bit c,
                      input bit r, input int unsigned addr);
    load_done    = ld;
    stall        = st;
    jump_en      = j;
    call_en      = c;
    ret_en       = r;
    jump_address = AW'(addr);
    @(posedge CLK);
    model_step(ld, st, j, c, r, addr);
    #1;
  endtask

  task automatic do_reset();
    {load_done, stall, jump_en, call_en, ret_en} = '0;
    jump_address = '0;
    RST = 1'b1;
    #2;
    model_reset();
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    {load_done, stall, jump_en, call_en, ret_en} = '1;
    jump_address = '1;
    RST = 1'b1;
    #3;
    vectors++;
    if ({program_counter, stack_level, stack_err, halted} !== '0) begin
      miscompares++;
      $display("FAIL reset: got pc=%0d lvl=%0d err=%b halt=%b, want all zero",
               program_counter, stack_level, stack_err, halted);
    end
    do_reset();
  endtask

  task automatic test_count_to_halt();
    do_reset();
    for (int i = 1; i <= 41; i++) begin
      if (i <= 31) tick(1, 0, 0, 0, 0, 0);
      else tick(1, 0, 1, 0, 0, 3);
      vectors++;
      if ({program_counter, stack_level, stack_err, halted} !== exp_state()) begin
        miscompares++;
        $display("FAIL count[%0d]: got pc=%0d lvl=%0d err=%b halt=%b, want pc=%0d lvl=%0d err=%b",
                 i, program_counter, stack_level, stack_err, halted, m_pc, m_level(), m_err);
      end
    end
  endtask

  task automatic test_call_return();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      case (i)
        4:       tick(1, 0, 0, 1, 0, 20);
        7:       tick(1, 0, 0, 0, 1, 0);
        default: tick(1, 0, 0, 0, 0, 0);
      endcase
      vectors++;
      if ({program_counter, stack_level, stack_err, halted} !== exp_state()) begin
        miscompares++;
        $display("FAIL call_ret[%0d]: got pc=%0d lvl=%0d err=%b halt=%b, want pc=%0d lvl=%0d err=%b",
                 i, program_counter, stack_level, stack_err, halted, m_pc, m_level(), m_err);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) tick(1, 0, 0, 1, 0, 2 + 4 * i);
      else tick(1, 0, 0, 0, 1, 0);
      vectors++;
      if ({program_counter, stack_level, stack_err, halted} !== exp_state()) begin
        miscompares++;
        $display("FAIL overflow[%0d]: got pc=%0d lvl=%0d err=%b halt=%b, want pc=%0d lvl=%0d err=%b",
                 i, program_counter, stack_level, stack_err, halted, m_pc, m_level(), m_err);
      end
    end
  endtask

  task automatic test_priority_stall();
    do_reset();
    repeat (9) tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       tick(1, 0, 1, 1, 1, 17);
        1:       tick(1, 1, 1, 0, 0, 3);
        default: tick(0, 0, 1, 1, 1, 3);
      endcase
      vectors++;
      if ({program_counter, stack_level, stack_err, halted} !== exp_state()) begin
        miscompares++;
        $display("FAIL prio_stall[%0d]: got pc=%0d lvl=%0d err=%b halt=%b, want pc=%0d lvl=%0d err=%b",
                 i, program_counter, stack_level, stack_err, halted, m_pc, m_level(), m_err);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 1, 0, 6);
    tick(1, 0, 0, 0, 0, 0);
    vectors++;
    if ({program_counter, stack_level, stack_err, halted} !== exp_state()) begin
      miscompares++;
      $display("FAIL async_pre: got pc=%0d lvl=%0d err=%b, want pc=%0d lvl=%0d err=%b",
               program_counter, stack_level, stack_err, m_pc, m_level(), m_err);
    end
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    vectors++;
    if ({program_counter, stack_level, stack_err, halted} !== exp_state()) begin
      miscompares++;
      $display("FAIL async_rst: got pc=%0d lvl=%0d err=%b halt=%b, want all zero",
               program_counter, stack_level, stack_err, halted);
    end
    #1;
    RST = 1'b0;
    tick(1, 0, 0, 0, 0, 0);
    vectors++;
    if ({program_counter, stack_level, stack_err, halted} !== exp_state()) begin
      miscompares++;
      $display("FAIL first_edge: got pc=%0d lvl=%0d, want pc=%0d lvl=%0d",
               program_counter, stack_level, m_pc, m_level());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_pc == PC_MAX && $urandom_range(3) == 0) do_reset();
      tick($urandom_range(7) != 0, $urandom_range(5) == 0, $urandom_range(3) == 0,
           $urandom_range(4) == 0, $urandom_range(4) == 0, $urandom_range(PC_MAX));
      vectors++;
      if ({program_counter, stack_level, stack_err, halted} !== exp_state()) begin
        miscompares++;
        $display("FAIL random[%0d]: got pc=%0d lvl=%0d err=%b halt=%b, want pc=%0d lvl=%0d err=%b",
                 i, program_counter, stack_level, stack_err, halted, m_pc, m_level(), m_err);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_count_to_halt();
    test_call_return();
    test_overflow();
    test_priority_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
